// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared state encoding, config struct, error bit indexes  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic       d_num;
        logic       s_num;
        logic [1:0] par;
    } cfg_t;

    localparam int c_err_start  = 0;
    localparam int c_err_parity = 1;
    localparam int c_err_stop   = 2;

    // 8 data bits, 1 stop bit, no parity
    localparam cfg_t c_cfg_reset = '{d_num: 1'b1, s_num: 1'b0, par: 2'b00};

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_ctrl_if : frame read-out port (valid/ready + FIFO level)    |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface uart_rx_ctrl_if #(
    parameter int DBITS = 8,
    parameter int DEPTH = 4
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             o_rd_valid;
    logic             i_rd_ready;
    logic [DBITS-1:0] o_rd_data;
    logic [2:0]       o_rd_err;
    logic [LVL_W-1:0] o_level;

    modport master (
        output o_rd_valid, o_rd_data, o_rd_err, o_level,
        input  i_rd_ready
    );

    modport slave (
        input  o_rd_valid, o_rd_data, o_rd_err, o_level,
        output i_rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, simultaneous push/pop when full      |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                       i_clk,
    input  wire logic                       i_rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_din,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_dout,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == c_depth);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees the slot the same cycle, so a push into a full FIFO is legal then
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_ctrl : UART receiver control - config, frame FIFO, errors   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBITS  = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 2
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_rx,
    input  wire logic             i_rx_done,
    input  wire logic [DBITS-1:0] i_rx_data,
    input  wire logic [2:0]       i_err,
    output logic                  o_d_num,
    output logic                  o_s_num,
    output logic      [1:0]       o_par,
    input  wire logic             i_cfg_wr,
    input  wire logic             i_cfg_d_num,
    input  wire logic             i_cfg_s_num,
    input  wire logic [1:0]       i_cfg_par,
    output logic                  o_cfg_ack,
    output logic                  o_busy,
    uart_rx_ctrl_if.master        rd,
    output logic                  o_overrun,
    output logic      [CNT_W-1:0] o_err_cnt,
    input  wire logic             i_clr,
    output logic                  o_irq
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] c_thresh = LVL_W'(THRESH);

    state_t           r_state;
    state_t           w_state_next;
    cfg_t             r_cfg;
    cfg_t             r_pend_cfg;
    logic             r_pend;
    logic             r_ack;
    logic             r_overrun;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_apply;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;
    logic [DBITS+2:0] w_dout;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Config only changes while the line is idle-high, never mid-frame
                w_apply = i_rx & r_pend;
                if (!i_rx) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                o_busy = 1'b1;
                if (i_rx_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg      <= c_cfg_reset;
            r_pend_cfg <= c_cfg_reset;
            r_pend     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) r_cfg <= r_pend_cfg;
            // A write in the apply cycle stays pending and is applied next
            if (i_cfg_wr) begin
                r_pend_cfg <= '{d_num: i_cfg_d_num, s_num: i_cfg_s_num, par: i_cfg_par};
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign w_pop  = rd.o_rd_valid & rd.i_rd_ready;
    assign w_drop = i_rx_done & w_full & ~w_pop;

    sync_fifo #(
        .WIDTH (DBITS + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_rx_done),
        .i_din   ({i_err, i_rx_data}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_drop) r_overrun <= 1'b1;
            if (i_rx_done && (i_err != 3'b000) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign rd.o_rd_valid = ~w_empty;
    assign rd.o_rd_data  = w_dout[DBITS-1:0];
    assign rd.o_rd_err   = w_dout[DBITS+2:DBITS];
    assign rd.o_level    = w_level;

    assign o_d_num   = r_cfg.d_num;
    assign o_s_num   = r_cfg.s_num;
    assign o_par     = r_cfg.par;
    assign o_cfg_ack = r_ack;
    assign o_overrun = r_overrun;
    assign o_err_cnt = r_err_cnt;
    assign o_irq     = (w_level >= c_thresh) | r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed self-checking bench for uart_rx_ctrl     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [2:0] err;
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
    logic       cfg_wr;
    logic       cfg_d_num;
    logic       cfg_s_num;
    logic [1:0] cfg_par;
    logic       cfg_ack;
    logic       busy;
    logic       overrun;
    logic [7:0] err_cnt;
    logic       clr;
    logic       irq;

    int n_total = 0;
    int n_bad   = 0;

    uart_rx_ctrl_if #(.DBITS(8), .DEPTH(4)) rd_if ();

    uart_rx_ctrl #(.DBITS(8), .DEPTH(4), .CNT_W(8), .THRESH(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_err       (err),
        .o_d_num     (d_num),
        .o_s_num     (s_num),
        .o_par       (par),
        .i_cfg_wr    (cfg_wr),
        .i_cfg_d_num (cfg_d_num),
        .i_cfg_s_num (cfg_s_num),
        .i_cfg_par   (cfg_par),
        .o_cfg_ack   (cfg_ack),
        .o_busy      (busy),
        .rd          (rd_if),
        .o_overrun   (overrun),
        .o_err_cnt   (err_cnt),
        .i_clr       (clr),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [2:0] e);
        rx_done = 1'b1;
        rx_data = d;
        err     = e;
        tick();
        rx_done = 1'b0;
        err     = 3'b000;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check(tag, 32'(rd_if.o_rd_data), 32'(d));
        rd_if.i_rd_ready = 1'b1;
        tick();
        rd_if.i_rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_done = 1'b0; rx_data = 8'h00; err = 3'b000;
        cfg_wr = 1'b0; cfg_d_num = 1'b0; cfg_s_num = 1'b0; cfg_par = 2'b00;
        clr = 1'b0; rd_if.i_rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_busy",    32'(busy), 0);
        check("rst_valid",   32'(rd_if.o_rd_valid), 0);
        check("rst_level",   32'(rd_if.o_level), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_errcnt",  32'(err_cnt), 0);
        check("rst_ack",     32'(cfg_ack), 0);
        check("rst_cfg",     32'({d_num, s_num, par}), 32'h8);
        check("rst_irq",     32'(irq), 0);

        // single frame
        push_frame(8'hA5, 3'b000);
        check("one_valid", 32'(rd_if.o_rd_valid), 1);
        check("one_level", 32'(rd_if.o_level), 1);
        check("one_irq",   32'(irq), 0);
        check("one_err",   32'(rd_if.o_rd_err), 0);
        pop_expect("one_data", 8'hA5);
        check("one_empty", 32'(rd_if.o_level), 0);

        // overflow: 5 frames into 4 entries
        for (int i = 1; i <= 5; i++) begin
            push_frame(8'(i), 3'b000);
            if (i == 2) check("thr_irq", 32'(irq), 1);
        end
        check("ovf_level",   32'(rd_if.o_level), 4);
        check("ovf_overrun", 32'(overrun), 1);
        check("ovf_irq",     32'(irq), 1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
        check("ovf_drained", 32'(rd_if.o_level), 0);
        check("ovf_irq_sticky", 32'(irq), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_overrun", 32'(overrun), 0);
        check("clr_irq",     32'(irq), 0);

        // pop while empty is ignored; push+pop while empty keeps the push
        rd_if.i_rd_ready = 1'b1;
        tick();
        check("emp_pop_level", 32'(rd_if.o_level), 0);
        push_frame(8'h77, 3'b000);
        rd_if.i_rd_ready = 1'b0;
        check("emp_pushpop_level", 32'(rd_if.o_level), 1);
        pop_expect("emp_pushpop_data", 8'h77);

        // full FIFO, push with simultaneous pop
        for (int i = 0; i < 4; i++) push_frame(8'h11 + 8'(i), 3'b000);
        rd_if.i_rd_ready = 1'b1;
        push_frame(8'h55, 3'b000);
        rd_if.i_rd_ready = 1'b0;
        check("fpp_level",   32'(rd_if.o_level), 4);
        check("fpp_overrun", 32'(overrun), 0);
        pop_expect("fpp_pop0", 8'h12);
        pop_expect("fpp_pop1", 8'h13);
        pop_expect("fpp_pop2", 8'h14);
        pop_expect("fpp_pop3", 8'h55);

        // config write while ACTIVE is deferred to the idle line
        rx = 1'b0;
        tick();
        check("act_busy", 32'(busy), 1);
        cfg_wr = 1'b1; cfg_d_num = 1'b0; cfg_s_num = 1'b1; cfg_par = 2'b01;
        tick();
        cfg_wr = 1'b0;
        rx = 1'b1;
        check("act_cfg_hold0", 32'({d_num, s_num, par}), 32'h8);
        tick();
        check("act_cfg_hold1", 32'({d_num, s_num, par}), 32'h8);
        check("act_ack_hold",  32'(cfg_ack), 0);
        check("act_busy_hold", 32'(busy), 1);
        push_frame(8'h3C, 3'b000);
        check("done_busy", 32'(busy), 0);
        check("done_ack",  32'(cfg_ack), 0);
        check("done_cfg",  32'({d_num, s_num, par}), 32'h8);
        tick();
        check("apply_ack", 32'(cfg_ack), 1);
        check("apply_cfg", 32'({d_num, s_num, par}), 32'h5);
        tick();
        check("apply_ack_once", 32'(cfg_ack), 0);
        check("apply_cfg_keep", 32'({d_num, s_num, par}), 32'h5);
        pop_expect("cfg_frame", 8'h3C);

        // error counter saturation, clear wins over simultaneous events
        for (int i = 0; i < 300; i++) push_frame(8'(i), 3'b100);
        check("sat_cnt",     32'(err_cnt), 255);
        check("sat_overrun", 32'(overrun), 1);
        check("sat_head",    32'(rd_if.o_rd_data), 0);
        check("sat_head_err", 32'(rd_if.o_rd_err), 4);
        clr = 1'b1;
        push_frame(8'hEE, 3'b001);
        clr = 1'b0;
        check("clrw_cnt",     32'(err_cnt), 0);
        check("clrw_overrun", 32'(overrun), 0);
        check("clrw_level",   32'(rd_if.o_level), 4);
        push_frame(8'hEF, 3'b010);
        check("post_cnt",     32'(err_cnt), 1);
        check("post_overrun", 32'(overrun), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 4; i++) pop_expect($sformatf("sat_pop%0d", i), 8'(i));

        // reset mid-frame with entries queued
        push_frame(8'hC1, 3'b000);
        push_frame(8'hC2, 3'b000);
        rx = 1'b0;
        tick();
        check("mid_busy",  32'(busy), 1);
        check("mid_level", 32'(rd_if.o_level), 2);
        rst = 1'b1; rx_done = 1'b1; rx_data = 8'hDD; err = 3'b111;
        tick();
        rst = 1'b0; rx_done = 1'b0; err = 3'b000; rx = 1'b1;
        check("mrst_busy",   32'(busy), 0);
        check("mrst_level",  32'(rd_if.o_level), 0);
        check("mrst_valid",  32'(rd_if.o_rd_valid), 0);
        check("mrst_cfg",    32'({d_num, s_num, par}), 32'h8);
        check("mrst_errcnt", 32'(err_cnt), 0);
        tick();
        check("mrst_noack",  32'(cfg_ack), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
